// File: rtl/lcd_ctrl_pkg.sv
// Shared command/state encodings for the LCD window controller.
// Pure declarations; no logic, no latency, no flow control.
package lcd_ctrl_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_MIRROR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {IDLE, LOAD, SETUP, OUT} state_e;

  typedef enum logic {MODE_FIT, MODE_ZOOM} mode_e;

endpackage

// File: rtl/lcd_frame_buf.sv
// Frame store: one synchronous write port, one combinational read port; contents not reset.
// Read data follows raddr in the same cycle; no flow control.
module lcd_frame_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 108,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_window_ctrl.sv
// LCD view controller: loads a frame, streams a WIN x WIN zoom-fit or zoom-in view; first pixel
// one setup cycle after accept. Output held stable while out_ready is low; commands ignored while busy.
module lcd_window_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_SX = 3,
  parameter int FIT_SY = 2,
  parameter int FIT_OX = 1,
  parameter int FIT_OY = 1,
  parameter int ORG_X0 = 4,
  parameter int ORG_Y0 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  input  logic [DW-1:0]    datain,
  input  logic             out_ready,
  output logic [DW-1:0]    dataout,
  output logic             output_valid,
  output logic             busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;

  if (FIT_OX + (WIN - 1) * FIT_SX >= IMG_W || FIT_OY + (WIN - 1) * FIT_SY >= IMG_H ||
      ORG_X0 < 0 || ORG_X0 > IMG_W - WIN || ORG_Y0 < 0 || ORG_Y0 > IMG_H - WIN) begin : g_param_err
    $error("lcd_window_ctrl: fit grid or initial origin outside the frame");
  end

  state_e          state, state_nxt;
  mode_e           mode;
  logic            mirror;
  logic [XW-1:0]   ox;
  logic [YW-1:0]   oy;
  logic [CW-1:0]   r, c, cc;
  logic [AW-1:0]   load_addr, rd_addr;
  logic [DW-1:0]   rd_data;
  logic            accept, load_last, hs, view_last;
  int              row, col;

  assign accept    = (state == IDLE) && cmd_valid;
  assign load_last = (load_addr == AW'(NPIX - 1));
  assign hs        = (state == OUT) && out_ready;
  assign view_last = (r == CW'(WIN - 1)) && (c == CW'(WIN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = (cmd_e'(cmd) == CMD_LOAD) ? LOAD : SETUP;
      LOAD:    if (load_last) state_nxt = SETUP;
      SETUP:   state_nxt = OUT;
      OUT:     if (hs && view_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_addr <= '0;
      r         <= '0;
      c         <= '0;
      ox        <= XW'(ORG_X0);
      oy        <= YW'(ORG_Y0);
      mode      <= MODE_FIT;
      mirror    <= 1'b0;
    end else begin
      if (accept) begin
        load_addr <= '0;
        r         <= '0;
        c         <= '0;
        case (cmd_e'(cmd))
          CMD_ZOOM_IN:  mode <= MODE_ZOOM;
          CMD_ZOOM_FIT: begin
            mode <= MODE_FIT;
            ox   <= XW'(ORG_X0);
            oy   <= YW'(ORG_Y0);
          end
          CMD_RIGHT: if (mode == MODE_ZOOM && ox != XW'(IMG_W - WIN)) ox <= ox + XW'(1);
          CMD_LEFT:  if (mode == MODE_ZOOM && ox != '0) ox <= ox - XW'(1);
          CMD_UP:    if (mode == MODE_ZOOM && oy != '0) oy <= oy - YW'(1);
          CMD_DOWN:  if (mode == MODE_ZOOM && oy != YW'(IMG_H - WIN)) oy <= oy + YW'(1);
          CMD_MIRROR: mirror <= ~mirror;
          default: ;
        endcase
      end
      if (state == LOAD) begin
        load_addr <= load_addr + AW'(1);
        if (load_last) begin
          mode <= MODE_FIT;
          ox   <= XW'(ORG_X0);
          oy   <= YW'(ORG_Y0);
        end
      end
      if (hs) begin
        if (c == CW'(WIN - 1)) begin
          c <= '0;
          r <= r + CW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

  // Mirroring only reorders columns inside the view; the sampled region is unchanged.
  always_comb begin
    cc = mirror ? (CW'(WIN - 1) - c) : c;
    if (mode == MODE_FIT) begin
      row = FIT_OY + int'(r) * FIT_SY;
      col = FIT_OX + int'(cc) * FIT_SX;
    end else begin
      row = int'(oy) + int'(r);
      col = int'(ox) + int'(cc);
    end
    rd_addr = AW'(row * IMG_W + col);
  end

  lcd_frame_buf #(.DW(DW), .DEPTH(NPIX), .AW(AW)) u_frame_buf (
    .clk   (clk),
    .we    (state == LOAD),
    .waddr (load_addr),
    .wdata (datain),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign output_valid = (state == OUT);
  assign dataout      = (state == OUT) ? rd_data : '0;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Bench for lcd_window_ctrl: directed scenarios plus random command streams on two parameter sets,
// checked against a view model built from frame coordinates.
module tb_lcd_window_ctrl;

  logic        clk = 1'b0;
  logic        reset, sel;
  logic [2:0]  cmd;
  logic        cmd_valid, out_ready;
  logic [11:0] datain;
  logic [7:0]  dout_a;
  logic [11:0] dout_b, dout_o;
  logic        vld_a, vld_b, busy_a, busy_b, vld_o, busy_o;

  always #5 clk = ~clk;

  lcd_window_ctrl u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid & ~sel), .datain(datain[7:0]),
    .out_ready(out_ready), .dataout(dout_a), .output_valid(vld_a), .busy(busy_a)
  );

  lcd_window_ctrl #(.DW(12), .IMG_W(16), .IMG_H(16), .WIN(8), .FIT_SX(2), .FIT_SY(2),
                    .FIT_OX(0), .FIT_OY(0), .ORG_X0(4), .ORG_Y0(4)) u_big (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid & sel), .datain(datain),
    .out_ready(out_ready), .dataout(dout_b), .output_valid(vld_b), .busy(busy_b)
  );

  assign dout_o = sel ? dout_b : {4'h0, dout_a};
  assign vld_o  = sel ? vld_b : vld_a;
  assign busy_o = sel ? busy_b : busy_a;

  int vectors = 0, miscompares = 0;
  int w, h, win, fsx, fsy, fox, foy, x0, y0, pmax;
  int m_ox, m_oy;
  bit m_zoom, m_mirror;
  int ld[256], fb[256];
  int exp_q[$], obs_q[$];
  int fit_tbl[16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    m_zoom = 0; m_mirror = 0; m_ox = x0; m_oy = y0;
  endfunction

  function automatic void model_cmd(input int code);
    case (code)
      0: begin for (int i = 0; i < w * h; i++) fb[i] = ld[i]; m_zoom = 0; m_ox = x0; m_oy = y0; end
      1: m_zoom = 1;
      2: begin m_zoom = 0; m_ox = x0; m_oy = y0; end
      3: if (m_zoom && m_ox < w - win) m_ox++;
      4: if (m_zoom && m_ox > 0) m_ox--;
      5: if (m_zoom && m_oy > 0) m_oy--;
      6: if (m_zoom && m_oy < h - win) m_oy++;
      default: m_mirror = ~m_mirror;
    endcase
    exp_q.delete();
    for (int r = 0; r < win; r++)
      for (int c = 0; c < win; c++) begin
        int cc;
        cc = m_mirror ? win - 1 - c : c;
        if (m_zoom) exp_q.push_back(fb[(m_oy + r) * w + m_ox + cc]);
        else        exp_q.push_back(fb[(foy + r * fsy) * w + fox + cc * fsx]);
      end
  endfunction

  // Issue one command and follow its view to completion; called just after a rising edge.
  task automatic do_cmd(input int code, input int stall_k, input int stall_n, input bit rnd,
                        input bit poke, input int rst_k);
    cmd = 3'(code); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_rise", 32'(busy_o), 32'd1);
    if (code == 0)
      for (int i = 0; i < w * h; i++) begin
        datain = 12'(ld[i]);
        @(posedge clk); #1;
      end
    model_cmd(code);
    obs_q.delete();
    chk("setup_gap", 32'(vld_o), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < win * win; k++) begin
      int ns;
      chk("pix_valid", 32'(vld_o), 32'd1);
      chk("pix_data", 32'(dout_o), 32'(exp_q[k]));
      obs_q.push_back(int'(dout_o));
      if (k == rst_k) begin
        reset = 1'b1; #1;
        chk("rst_valid", 32'(vld_o), 32'd0);
        chk("rst_data", 32'(dout_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        return;
      end
      ns = (k == stall_k) ? stall_n : (rnd && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (ns > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < ns; s++) begin
          @(posedge clk); #1;
          chk("hold_data", 32'(dout_o), 32'(exp_q[k]));
          chk("hold_valid", 32'(vld_o), 32'd1);
        end
        out_ready = 1'b1;
      end
      if (poke && k == 2) begin cmd = 3'd1; cmd_valid = 1'b1; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    chk("end_valid", 32'(vld_o), 32'd0);
    chk("end_busy", 32'(busy_o), 32'd0);
  endtask

  task automatic plain(input int code);
    do_cmd(code, -1, 0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; cmd = '0; cmd_valid = 1'b0; out_ready = 1'b1; datain = '0;
    w = 12; h = 9; win = 4; fsx = 3; fsy = 2; fox = 1; foy = 1; x0 = 4; y0 = 3; pmax = 255;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(vld_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_data", 32'(dout_o), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 108; i++) ld[i] = i;
    plain(0);
    for (int k = 0; k < 16; k++) chk("load_fit_tbl", 32'(obs_q[k]), 32'(fit_tbl[k]));
    plain(2);
    for (int k = 0; k < 16; k++) chk("zoom_fit_tbl", 32'(obs_q[k]), 32'(fit_tbl[k]));
    do_cmd(2, 5, 3, 1'b0, 1'b0, -1);

    plain(1);
    for (int k = 0; k < 4; k++) chk("zoom_in_row0", 32'(obs_q[k]), 32'(40 + k));
    repeat (5) plain(3);
    chk("right_clamp", 32'(obs_q[0]), 32'd44);
    repeat (4) plain(4);
    plain(7);
    for (int k = 0; k < 4; k++) chk("mirror_row0", 32'(obs_q[k]), 32'(43 - k));
    chk("mirror_row1", 32'(obs_q[4]), 32'd55);
    plain(7);
    chk("unmirror", 32'(obs_q[0]), 32'd40);

    do_cmd(2, -1, 0, 1'b0, 1'b1, -1);
    plain(5);
    plain(1);
    chk("fit_up_origin", 32'(obs_q[0]), 32'd40);

    plain(6);
    do_cmd(1, -1, 0, 1'b0, 1'b0, 7);
    plain(1);
    chk("post_reset_origin", 32'(obs_q[0]), 32'd40);

    for (int i = 0; i < 108; i++) ld[i] = int'($urandom_range(0, pmax));
    plain(0);
    for (int n = 0; n < 40; n++) begin
      int code;
      code = int'($urandom_range(0, 7));
      if (code == 0) for (int i = 0; i < 108; i++) ld[i] = int'($urandom_range(0, pmax));
      do_cmd(code, -1, 0, 1'b1, 1'b0, -1);
    end

    sel = 1'b1;
    w = 16; h = 16; win = 8; fsx = 2; fsy = 2; fox = 0; foy = 0; x0 = 4; y0 = 4; pmax = 4095;
    model_reset();
    for (int i = 0; i < 256; i++) ld[i] = int'($urandom_range(0, pmax));
    plain(0);
    plain(1);
    for (int n = 0; n < 25; n++) do_cmd(int'($urandom_range(1, 7)), -1, 0, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
